// File: rtl/ram1k_pkg.sv
// Shared constants and types for the RAM1K select path (decoder and encoder sides).
// The output state type is exported so the encoder can present its state for observation.
package ram1k_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } enc_state_e;

    function automatic logic [N_REQ-1:0] onehot8(input logic [CODE_W-1:0] code);
        logic [N_REQ-1:0] v;
        v = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_prio_enc8.sv
// Combinational priority encoder that scans mask starting at index start, wrapping 7 -> 0.
// With start tied to 0 it is a plain lowest-index-wins encoder.
module rr_prio_enc8
    import ram1k_pkg::*;
(
    input  logic [N_REQ-1:0]  mask,
    input  logic [CODE_W-1:0] start,
    output logic [CODE_W-1:0] code,
    output logic              any
);

    logic [CODE_W-1:0] idx;

    always_comb begin
        code = '0;
        any  = 1'b0;
        idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = start + CODE_W'(i);
            if (!any && mask[idx]) begin
                code = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pending_encoder_8to3.sv
// Collects request pulses into a pending register and offers one 3-bit code per
// valid/ready transfer; fixed priority or round-robin selection.
module pending_encoder_8to3
    import ram1k_pkg::*;
#(
    parameter int ROUND_ROBIN = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [N_REQ-1:0]  Req_In,
    input  logic              Out_Ready,
    output logic [CODE_W-1:0] Out_Code,
    output logic              Out_Valid,
    output logic [N_REQ-1:0]  Pending,
    output logic              Ovf,
    output enc_state_e        Dbg_State
);

    // Handshake: a code transfers on a rising edge where Out_Valid and Out_Ready are both
    // high; Out_Code/Out_Valid hold while Out_Valid=1 and Out_Ready=0; Out_Ready is
    // ignored while Out_Valid=0.

    enc_state_e        state_q, state_d;
    logic [N_REQ-1:0]  pend_q, pend_d;
    logic [CODE_W-1:0] ptr_q, ptr_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              ovf_q, ovf_d;

    logic              handshake;
    logic [N_REQ-1:0]  served;
    logic [N_REQ-1:0]  captured;
    logic [N_REQ-1:0]  sel_mask;
    logic [CODE_W-1:0] sel_start;
    logic [CODE_W-1:0] sel_code;
    logic              sel_any;

    rr_prio_enc8 u_enc (
        .mask  (sel_mask),
        .start (sel_start),
        .code  (sel_code),
        .any   (sel_any)
    );

    always_comb begin
        handshake = (state_q == ST_HOLD) && Out_Ready;
        served    = handshake ? onehot8(code_q) : '0;
        captured  = Req_In & {N_REQ{EN}};
        // Same-cycle requests only land in pending; they are offered a cycle later.
        sel_mask  = pend_q & ~served;
        sel_start = (ROUND_ROBIN != 0) ? ptr_q : '0;
        pend_d    = sel_mask | captured;
        ovf_d     = |(captured & sel_mask);
        ptr_d     = handshake ? code_q + CODE_W'(1) : ptr_q;
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (sel_any) begin
                    code_d  = sel_code;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (Out_Ready) begin
                    if (sel_any) begin
                        code_d = sel_code;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            pend_q  <= '0;
            ptr_q   <= '0;
            code_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Out_Code  = code_q;
    assign Out_Valid = (state_q == ST_HOLD);
    assign Pending   = pend_q;
    assign Ovf       = ovf_q;
    assign Dbg_State = state_q;

endmodule

// File: tb/tb_pending_encoder_8to3.sv
// Bench for pending_encoder_8to3: fixed-priority and round-robin instances share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_pending_encoder_8to3;
    import ram1k_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b0;
    logic [7:0] req = 8'h00;
    logic       rdy = 1'b0;

    logic [2:0] fix_code, rr_code;
    logic       fix_valid, rr_valid;
    logic [7:0] fix_pend, rr_pend;
    logic       fix_ovf, rr_ovf;
    enc_state_e fix_st, rr_st;

    int checks = 0;
    int errors = 0;

    // reference model state, index 0 = fixed priority, 1 = round robin
    logic [7:0] mp[2];
    logic       mv[2];
    int         mc[2];
    logic       mo[2];
    int         mptr[2];

    always #5 CLK = ~CLK;

    pending_encoder_8to3 #(.ROUND_ROBIN(0)) u_fix (
        .CLK(CLK), .RST(RST), .EN(EN), .Req_In(req), .Out_Ready(rdy),
        .Out_Code(fix_code), .Out_Valid(fix_valid), .Pending(fix_pend), .Ovf(fix_ovf),
        .Dbg_State(fix_st)
    );

    pending_encoder_8to3 #(.ROUND_ROBIN(1)) u_rr (
        .CLK(CLK), .RST(RST), .EN(EN), .Req_In(req), .Out_Ready(rdy),
        .Out_Code(rr_code), .Out_Valid(rr_valid), .Pending(rr_pend), .Ovf(rr_ovf),
        .Dbg_State(rr_st)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            mp[r] = 8'h00; mv[r] = 1'b0; mc[r] = 0; mo[r] = 1'b0; mptr[r] = 0;
        end
    endtask

    // One clock of behaviour: serve the offered code, pick the next one from what
    // remains (scanning from the rotation start), then absorb the new requests.
    task automatic model_step(input logic en_i, input logic [7:0] req_i, input logic rdy_i);
        logic [7:0] served, remaining, captured;
        int start, found, idx;
        for (int r = 0; r < 2; r++) begin
            served    = (mv[r] && rdy_i) ? 8'(1 << mc[r]) : 8'h00;
            remaining = mp[r] & ~served;
            captured  = en_i ? req_i : 8'h00;
            start     = (r == 1) ? mptr[r] : 0;
            found     = -1;
            for (int k = 0; k < 8; k++) begin
                idx = (start + k) % 8;
                if (found < 0 && remaining[idx]) found = idx;
            end
            if (mv[r] && rdy_i) mptr[r] = (mc[r] + 1) % 8;
            mo[r] = (captured & remaining) != 8'h00;
            if (!mv[r] || rdy_i) begin
                if (found >= 0) begin
                    mv[r] = 1'b1;
                    mc[r] = found;
                end else begin
                    mv[r] = 1'b0;
                end
            end
            mp[r] = remaining | captured;
        end
    endtask

    task automatic compare_all();
        check("fix_pending", fix_pend, mp[0]);
        check("fix_valid", 8'(fix_valid), 8'(mv[0]));
        check("fix_code", 8'(fix_code), 8'(mc[0]));
        check("fix_ovf", 8'(fix_ovf), 8'(mo[0]));
        check("rr_pending", rr_pend, mp[1]);
        check("rr_valid", 8'(rr_valid), 8'(mv[1]));
        check("rr_code", 8'(rr_code), 8'(mc[1]));
        check("rr_ovf", 8'(rr_ovf), 8'(mo[1]));
    endtask

    task automatic cycle(input logic en_i, input logic [7:0] req_i, input logic rdy_i);
        EN = en_i; req = req_i; rdy = rdy_i;
        model_step(en_i, req_i, rdy_i);
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        #2 RST = 1'b1;
        model_reset();
        #1;
        check("rst_code", 8'(fix_code), 8'h00);
        check("rst_valid", 8'(fix_valid), 8'h00);
        check("rst_pend", fix_pend, 8'h00);
        check("rst_ovf", 8'(fix_ovf), 8'h00);
        check("rst_rr_valid", 8'(rr_valid), 8'h00);
        EN = 1'b0; req = 8'h00; rdy = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    initial begin
        // power-on reset
        do_reset();
        compare_all();

        // fill everything, hold the offer, then reset mid-transfer
        cycle(1, 8'hFF, 0);
        cycle(1, 8'h00, 0);
        check("pre_rst_pend", fix_pend, 8'hFF);
        check("pre_rst_valid", 8'(fix_valid), 8'h01);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 8'h00, 0);
            check("idle_valid", 8'(fix_valid), 8'h00);
        end

        // single request, fixed priority
        cycle(1, 8'h20, 1);
        check("single_pend", fix_pend, 8'h20);
        check("single_valid_lat", 8'(fix_valid), 8'h00);
        cycle(1, 8'h00, 1);
        check("single_valid", 8'(fix_valid), 8'h01);
        check("single_code", 8'(fix_code), 8'h05);
        cycle(1, 8'h00, 1);
        check("single_drain_pend", fix_pend, 8'h00);
        check("single_drain_valid", 8'(fix_valid), 8'h00);

        // multi-request, fixed priority: 0, 4, 7
        cycle(1, 8'h91, 1);
        cycle(1, 8'h00, 1);
        check("multi_code0", 8'(fix_code), 8'h00);
        cycle(1, 8'h00, 1);
        check("multi_code4", 8'(fix_code), 8'h04);
        cycle(1, 8'h00, 1);
        check("multi_code7", 8'(fix_code), 8'h07);
        cycle(1, 8'h00, 1);
        check("multi_end_valid", 8'(fix_valid), 8'h00);

        // round-robin: serve 4, then {0,4,5} served as 5, 0, 4
        do_reset();
        cycle(1, 8'h10, 1);
        cycle(1, 8'h00, 1);
        check("rr_first", 8'(rr_code), 8'h04);
        cycle(1, 8'h31, 1);
        cycle(1, 8'h00, 1);
        check("rr_5", 8'(rr_code), 8'h05);
        cycle(1, 8'h00, 1);
        check("rr_0", 8'(rr_code), 8'h00);
        check("fix_vs_rr_1", 8'(fix_code), 8'h04);
        cycle(1, 8'h00, 1);
        check("rr_4", 8'(rr_code), 8'h04);
        cycle(1, 8'h00, 1);
        // pointer wrap: serve 7 (ptr -> 0), then {1,7} gives 1 then 7
        cycle(1, 8'h80, 1);
        cycle(1, 8'h00, 1);
        check("rr_7", 8'(rr_code), 8'h07);
        cycle(1, 8'h82, 1);
        cycle(1, 8'h00, 1);
        check("rr_wrap_1", 8'(rr_code), 8'h01);
        cycle(1, 8'h00, 1);
        check("rr_wrap_7", 8'(rr_code), 8'h07);
        cycle(1, 8'h00, 1);

        // backpressure: code 2 held stable, later request does not disturb it
        do_reset();
        cycle(1, 8'h04, 0);
        cycle(1, 8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, (i == 2) ? 8'h01 : 8'h00, 0);
            check("bp_stable_code", 8'(fix_code), 8'h02);
            check("bp_stable_valid", 8'(fix_valid), 8'h01);
        end
        cycle(1, 8'h00, 1);
        check("bp_next_code", 8'(fix_code), 8'h00);
        cycle(1, 8'h00, 1);
        check("bp_done_valid", 8'(fix_valid), 8'h00);

        // overflow / collision
        do_reset();
        cycle(1, 8'h08, 0);
        cycle(1, 8'h00, 0);
        cycle(1, 8'h08, 0);
        check("ovf_pulse", 8'(fix_ovf), 8'h01);
        check("ovf_pend", fix_pend, 8'h08);
        cycle(1, 8'h00, 0);
        check("ovf_one_cycle", 8'(fix_ovf), 8'h00);
        cycle(1, 8'h08, 1);
        check("collide_no_ovf", 8'(fix_ovf), 8'h00);
        check("collide_pend", fix_pend, 8'h08);
        cycle(0, 8'hFF, 0);
        check("en_low_pend", fix_pend, 8'h08);
        check("en_low_ovf", 8'(fix_ovf), 8'h00);
        cycle(0, 8'hFF, 1);
        check("en_low_drain", fix_pend, 8'h00);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                  ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
